// File: rtl/ex_muldiv_stage.sv
// EX stage of a MIPS-style pipeline: forwarding muxes, ALU, and an iterative
// multiply/divide unit that owns the HI/LO registers.
module ex_muldiv_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [31:0]           id_ex_instr,
    input  logic [1:0]            id_ex_alu_op,
    input  logic [DATA_WIDTH-1:0] id_ex_reg1,
    input  logic [DATA_WIDTH-1:0] id_ex_reg2,
    input  logic [DATA_WIDTH-1:0] id_ex_imm_value,
    input  logic [DATA_WIDTH-1:0] ex_mem_alu_result,
    input  logic [DATA_WIDTH-1:0] mem_wb_write_back_result,
    input  logic                  id_ex_alu_src,
    input  logic [1:0]            Forward_A,
    input  logic [1:0]            Forward_B,
    output logic [DATA_WIDTH-1:0] alu_in2_out,
    output logic [DATA_WIDTH-1:0] alu_result,
    output logic                  stall,
    output logic                  muldiv_busy,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    localparam logic [5:0] F_MFHI = 6'h10;
    localparam logic [5:0] F_MTHI = 6'h11;
    localparam logic [5:0] F_MFLO = 6'h12;
    localparam logic [5:0] F_MTLO = 6'h13;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;

    logic [5:0]     funct_s;
    logic           unused_instr_s;
    logic [W-1:0]   op1_s, fwd_b_s, op2_s, alu_res_s;
    logic           is_rtype_s, is_hilo_s, is_muldiv_s, start_s, busy_s;
    logic           wr_hi_s, wr_lo_s, slt_s;
    logic           is_signed_s, a_neg_s, b_neg_s;
    logic [W-1:0]   a_mag_s, b_mag_s;
    logic [W:0]     mul_sum_s, div_shift_s, div_diff_s;
    logic [W-1:0]   mul_hi_nxt_s, mul_lo_nxt_s, div_hi_nxt_s, div_lo_nxt_s;
    logic [2*W-1:0] prod_s, prod_fin_s;
    logic [W-1:0]   div_hi_fin_s, div_lo_fin_s;

    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [W-1:0]     hi_r, lo_r, acc_hi_r, acc_lo_r, opd_r, dividend_r;
    logic             neg_res_r, neg_rem_r, div_zero_r;

    assign funct_s        = id_ex_instr[5:0];
    assign unused_instr_s = ^id_ex_instr[31:6];
    assign busy_s         = (state_r != ST_IDLE);

    // Forwarding muxes and operand-B source select
    always_comb begin
        case (Forward_A)
            2'b01:   op1_s = mem_wb_write_back_result;
            2'b10:   op1_s = ex_mem_alu_result;
            default: op1_s = id_ex_reg1;
        endcase
        case (Forward_B)
            2'b01:   fwd_b_s = mem_wb_write_back_result;
            2'b10:   fwd_b_s = ex_mem_alu_result;
            default: fwd_b_s = id_ex_reg2;
        endcase
        if (id_ex_alu_src) begin
            op2_s = id_ex_imm_value;
        end else begin
            op2_s = fwd_b_s;
        end
    end

    // HI/LO instruction decode and unit start / move-to qualifiers
    always_comb begin
        is_rtype_s  = (id_ex_alu_op == 2'b10);
        is_muldiv_s = is_rtype_s && (funct_s[5:2] == 4'b0110);
        case (funct_s)
            F_MFHI, F_MTHI, F_MFLO, F_MTLO: is_hilo_s = is_rtype_s;
            default:                        is_hilo_s = is_muldiv_s;
        endcase
        start_s = in_valid && is_muldiv_s && !busy_s;
        wr_hi_s = in_valid && is_rtype_s && (funct_s == F_MTHI) && !busy_s;
        wr_lo_s = in_valid && is_rtype_s && (funct_s == F_MTLO) && !busy_s;
    end

    // Main ALU
    always_comb begin
        slt_s     = ($signed(op1_s) < $signed(op2_s));
        alu_res_s = {W{1'b0}};
        case (id_ex_alu_op)
            2'b00: alu_res_s = op1_s + op2_s;
            2'b01: alu_res_s = op1_s - op2_s;
            2'b11: alu_res_s = op1_s | op2_s;
            2'b10: begin
                case (funct_s)
                    F_ADD:   alu_res_s = op1_s + op2_s;
                    F_SUB:   alu_res_s = op1_s - op2_s;
                    F_AND:   alu_res_s = op1_s & op2_s;
                    F_OR:    alu_res_s = op1_s | op2_s;
                    F_NOR:   alu_res_s = ~(op1_s | op2_s);
                    F_SLT:   alu_res_s = {{(W-1){1'b0}}, slt_s};
                    F_MFHI:  alu_res_s = hi_r;
                    F_MFLO:  alu_res_s = lo_r;
                    default: alu_res_s = {W{1'b0}};
                endcase
            end
            default: alu_res_s = {W{1'b0}};
        endcase
    end

    // Operand magnitudes; funct bit 0 clear means the signed variant
    always_comb begin
        is_signed_s = !funct_s[0];
        a_neg_s     = is_signed_s && op1_s[W-1];
        b_neg_s     = is_signed_s && fwd_b_s[W-1];
        if (a_neg_s) begin
            a_mag_s = -op1_s;
        end else begin
            a_mag_s = op1_s;
        end
        if (b_neg_s) begin
            b_mag_s = -fwd_b_s;
        end else begin
            b_mag_s = fwd_b_s;
        end
    end

    // One shift-add / restoring-divide step plus sign fix-up of the final step
    always_comb begin
        mul_sum_s    = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opd_r} : {(W+1){1'b0}});
        mul_hi_nxt_s = mul_sum_s[W:1];
        mul_lo_nxt_s = {mul_sum_s[0], acc_lo_r[W-1:1]};
        div_shift_s  = {acc_hi_r, acc_lo_r[W-1]};
        div_diff_s   = div_shift_s - {1'b0, opd_r};
        if (!div_diff_s[W]) begin
            div_hi_nxt_s = div_diff_s[W-1:0];
            div_lo_nxt_s = {acc_lo_r[W-2:0], 1'b1};
        end else begin
            div_hi_nxt_s = div_shift_s[W-1:0];
            div_lo_nxt_s = {acc_lo_r[W-2:0], 1'b0};
        end
        prod_s = {mul_hi_nxt_s, mul_lo_nxt_s};
        if (neg_res_r) begin
            prod_fin_s = -prod_s;
        end else begin
            prod_fin_s = prod_s;
        end
        if (div_zero_r) begin
            div_hi_fin_s = dividend_r;
            div_lo_fin_s = {W{1'b1}};
        end else begin
            div_hi_fin_s = neg_rem_r ? -div_hi_nxt_s : div_hi_nxt_s;
            div_lo_fin_s = neg_res_r ? -div_lo_nxt_s : div_lo_nxt_s;
        end
    end

    // Multiply/divide FSM, iteration registers and HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            hi_r       <= {W{1'b0}};
            lo_r       <= {W{1'b0}};
            acc_hi_r   <= {W{1'b0}};
            acc_lo_r   <= {W{1'b0}};
            opd_r      <= {W{1'b0}};
            dividend_r <= {W{1'b0}};
            neg_res_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            div_zero_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= {CNT_W{1'b0}};
                    if (start_s) begin
                        state_r    <= funct_s[1] ? ST_DIV : ST_MUL;
                        acc_hi_r   <= {W{1'b0}};
                        acc_lo_r   <= funct_s[1] ? a_mag_s : b_mag_s;
                        opd_r      <= funct_s[1] ? b_mag_s : a_mag_s;
                        dividend_r <= op1_s;
                        neg_res_r  <= a_neg_s ^ b_neg_s;
                        neg_rem_r  <= a_neg_s;
                        div_zero_r <= (fwd_b_s == {W{1'b0}});
                    end
                    if (wr_hi_s) begin
                        hi_r <= op1_s;
                    end
                    if (wr_lo_s) begin
                        lo_r <= op1_s;
                    end
                end
                ST_MUL: begin
                    cnt_r    <= cnt_r + CNT_W'(1);
                    acc_hi_r <= mul_hi_nxt_s;
                    acc_lo_r <= mul_lo_nxt_s;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_IDLE;
                        hi_r    <= prod_fin_s[2*W-1:W];
                        lo_r    <= prod_fin_s[W-1:0];
                    end
                end
                ST_DIV: begin
                    cnt_r    <= cnt_r + CNT_W'(1);
                    acc_hi_r <= div_hi_nxt_s;
                    acc_lo_r <= div_lo_nxt_s;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_IDLE;
                        hi_r    <= div_hi_fin_s;
                        lo_r    <= div_lo_fin_s;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign alu_in2_out = fwd_b_s;
    assign alu_result  = alu_res_s;
    assign stall       = busy_s && in_valid && is_hilo_s;
    assign muldiv_busy = busy_s;
    assign hi_out      = hi_r;
    assign lo_out      = lo_r;
endmodule

// File: doc/ex_muldiv_stage.md
EX_MULDIV_STAGE -- requirements
Module: ex_muldiv_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: datapath width W, even and >= 8.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1: the ID/EX register holds a live instruction.
REQ-005 SHALL have port id_ex_instr, input, 32: instruction; bits [5:0] are funct.
REQ-006 SHALL have port id_ex_alu_op, input, 2: ALU operation class.
REQ-007 SHALL have ports id_ex_reg1, id_ex_reg2, id_ex_imm_value, inputs, W each: rs, rt and extended immediate.
REQ-008 SHALL have ports ex_mem_alu_result, mem_wb_write_back_result, inputs, W each: forwarding sources.
REQ-009 SHALL have port id_ex_alu_src, input, 1: 1 selects the immediate as ALU operand B.
REQ-010 SHALL have ports Forward_A, Forward_B, inputs, 2 each: forwarding selects.
REQ-011 SHALL have port alu_in2_out, output, W: forwarded rt value, taken before the alu_src mux.
REQ-012 SHALL have port alu_result, output, W: EX result.
REQ-013 SHALL have port stall, output, 1: hold IF/ID/EX and insert a bubble downstream.
REQ-014 SHALL have port muldiv_busy, output, 1: iterative unit is running.
REQ-015 SHALL have ports hi_out, lo_out, outputs, W each: the HI and LO registers.

Function
REQ-016 Forwarding mux SHALL select by Forward_X: 00 = reg, 01 = mem_wb, 10 = ex_mem, 11 = reg; output A is op1 and output B is fwdB.
REQ-017 op2 SHALL be id_ex_imm_value when id_ex_alu_src is 1, else fwdB.
REQ-018 alu_op 00 SHALL produce op1+op2, 01 SHALL produce op1-op2, and 11 SHALL produce op1|op2.
REQ-019 alu_op 10 SHALL decode funct as: 0x20 add; 0x22 sub; 0x24 and; 0x25 or; 0x27 nor; 0x2A signed slt giving 1 or 0; 0x10 HI; 0x12 LO; any other funct gives 0. All arithmetic SHALL wrap modulo 2^W.
REQ-020 A HI/LO op SHALL be alu_op 10 with funct 0x10 mfhi, 0x11 mthi, 0x12 mflo, 0x13 mtlo, 0x18 mult, 0x19 multu, 0x1A div or 0x1B divu.
REQ-021 A start SHALL occur when in_valid, funct is 0x18-0x1B, and muldiv_busy is 0. The start SHALL latch op1 and fwdB, and the instruction SHALL leave EX without stalling.
REQ-022 FSM states SHALL be IDLE, MUL and DIV. A start SHALL move IDLE to MUL or DIV. After exactly W busy cycles the FSM SHALL write HI/LO and return to IDLE on the same edge.
REQ-023 The iteration SHALL be an unsigned shift-add multiply or restoring divide over magnitudes. For signed ops the sign SHALL be corrected at completion.
REQ-024 mult/multu SHALL write {HI,LO} as the 2W-bit product.
REQ-025 div/divu SHALL write LO = quotient truncated toward zero and HI = remainder with the sign of the dividend.
REQ-026 Divide by zero SHALL write HI = dividend and LO = all ones.
REQ-027 Signed MIN / -1 SHALL write LO = MIN and HI = 0.
REQ-028 stall SHALL equal muldiv_busy AND in_valid AND (instruction is a HI/LO op), combinationally. Non-HI/LO instructions SHALL proceed while busy.
REQ-029 mthi/mtlo SHALL write op1 to HI/LO at the edge, only when not busy.
REQ-030 mfhi/mflo SHALL read the registered HI/LO. A read in the cycle after the completion edge SHALL see the new value.
REQ-031 A start SHALL NOT be accepted in the completion cycle itself; stall is high in that cycle.

Reset
REQ-032 While reset is high, the FSM SHALL go to IDLE and the counter, HI and LO SHALL clear to 0. muldiv_busy and stall SHALL be 0 from the next cycle.
REQ-033 Reset mid-operation SHALL abort the operation, discard the partial result, and leave HI = LO = 0.

Verification (W=32)
REQ-034 mult, op1 = 7, fwdB = 0xFFFFFFFD, then mflo in the next cycle -> stall high exactly 32 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFEB, alu_result = 0xFFFFFFEB.
REQ-035 divu 100/7 -> LO = 14, HI = 2; div 0xFFFFFFF9/2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
REQ-036 div 5/0 -> HI = 5, LO = 0xFFFFFFFF; div 0x80000000/0xFFFFFFFF -> LO = 0x80000000, HI = 0.
REQ-037 Forward_A = 10, ex_mem = 0x10, reg2 = 3, funct 0x20 -> alu_result = 0x13. Forward_B = 01, mem_wb = 5, alu_src = 1, imm = 4, alu_op 00 -> alu_in2_out = 5, alu_result = op1 + 4.
REQ-038 add issued during busy cycle 5 -> stall = 0 and correct result. mult issued during busy -> stall = 1 until completion.
REQ-039 reset pulsed in busy cycle 10 -> next cycle muldiv_busy = 0, hi_out = lo_out = 0, stall = 0.
